// File: rtl/single_stream_argmin.sv
// Streaming binary32 running-minimum / argmin tracker over s_last-framed samples.
// Each frame produces one held result (min, index, length, NaN/empty/overflow flags).
module single_stream_argmin #(
    parameter int unsigned IDX_W     = 16,
    parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [31:0]        m_min,
    output logic [IDX_W-1:0]   m_idx,
    output logic [IDX_W:0]     m_len,
    output logic               m_nan,
    output logic               m_empty,
    output logic               m_ovf,
    output logic               m_valid,
    input  logic               m_ready
);
    localparam int unsigned POS_W = IDX_W + 1;

    typedef enum logic {ACC, OUT} state_t;

    // Sign-magnitude less-than; -0 and +0 compare equal.
    function automatic logic f32_lt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[31] != b[31]) r = a[31] && ((a[30:0] | b[30:0]) != 31'd0);
        else if (!a[31])    r = a[30:0] < b[30:0];
        else                r = a[30:0] > b[30:0];
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [31:0]        min_q, min_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               have_q, have_d;
    logic               nan_q, nan_d;
    logic               ovf_q, ovf_d;

    logic               s_ready_d, m_valid_d;
    logic [31:0]        m_min_d;
    logic [IDX_W-1:0]   m_idx_d;
    logic [POS_W-1:0]   m_len_d;
    logic               m_nan_d, m_empty_d, m_ovf_d;

    logic               accept_c, is_nan_c, in_range_c, take_c;
    logic [POS_W-1:0]   pos_inc_c;
    logic [31:0]        min_fin_c;
    logic [IDX_W-1:0]   idx_fin_c;
    logic               have_fin_c, nan_fin_c, ovf_fin_c;

    // Accumulator values as they stand after including the current sample.
    assign accept_c   = s_valid && s_ready;
    assign is_nan_c   = (s_data[30:23] == 8'hFF) && (s_data[22:0] != 23'd0);
    assign in_range_c = !pos_q[IDX_W];
    assign take_c     = accept_c && !is_nan_c && in_range_c && (!have_q || f32_lt(s_data, min_q));
    assign pos_inc_c  = (&pos_q) ? pos_q : pos_q + POS_W'(1);
    assign min_fin_c  = take_c ? s_data : min_q;
    assign idx_fin_c  = take_c ? pos_q[IDX_W-1:0] : idx_q;
    assign have_fin_c = have_q || take_c;
    assign nan_fin_c  = nan_q || (accept_c && is_nan_c);
    assign ovf_fin_c  = ovf_q || (accept_c && !in_range_c);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        min_d     = min_q;
        idx_d     = idx_q;
        have_d    = have_q;
        nan_d     = nan_q;
        ovf_d     = ovf_q;
        s_ready_d = s_ready;
        m_valid_d = m_valid;
        m_min_d   = m_min;
        m_idx_d   = m_idx;
        m_len_d   = m_len;
        m_nan_d   = m_nan;
        m_empty_d = m_empty;
        m_ovf_d   = m_ovf;
        if (state_q == ACC) begin
            if (accept_c && s_last) begin
                state_d   = OUT;
                s_ready_d = 1'b0;
                m_valid_d = 1'b1;
                m_min_d   = have_fin_c ? min_fin_c : NAN_VALUE;
                m_idx_d   = have_fin_c ? idx_fin_c : '0;
                m_len_d   = pos_inc_c;
                m_nan_d   = nan_fin_c;
                m_empty_d = !have_fin_c;
                m_ovf_d   = ovf_fin_c;
            end else if (accept_c) begin
                pos_d  = pos_inc_c;
                min_d  = min_fin_c;
                idx_d  = idx_fin_c;
                have_d = have_fin_c;
                nan_d  = nan_fin_c;
                ovf_d  = ovf_fin_c;
            end
        end else if (m_ready) begin
            state_d   = ACC;
            s_ready_d = 1'b1;
            m_valid_d = 1'b0;
            pos_d     = '0;
            min_d     = '0;
            idx_d     = '0;
            have_d    = 1'b0;
            nan_d     = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            pos_q   <= '0;
            min_q   <= '0;
            idx_q   <= '0;
            have_q  <= 1'b0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_min   <= NAN_VALUE;
            m_idx   <= '0;
            m_len   <= '0;
            m_nan   <= 1'b0;
            m_empty <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            have_q  <= have_d;
            nan_q   <= nan_d;
            ovf_q   <= ovf_d;
            s_ready <= s_ready_d;
            m_valid <= m_valid_d;
            m_min   <= m_min_d;
            m_idx   <= m_idx_d;
            m_len   <= m_len_d;
            m_nan   <= m_nan_d;
            m_empty <= m_empty_d;
            m_ovf   <= m_ovf_d;
        end
    end
endmodule

// File: tb/tb_single_stream_argmin.sv
// Directed bench for single_stream_argmin: a default-width instance and an IDX_W=2
// instance share one stimulus stream; expected values are hand-computed.
module tb_single_stream_argmin;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid, s_last, m_ready;

    logic        s_ready, m_nan, m_empty, m_ovf, m_valid;
    logic [31:0] m_min;
    logic [15:0] m_idx;
    logic [16:0] m_len;

    logic        s_ready2, m_nan2, m_empty2, m_ovf2, m_valid2;
    logic [31:0] m_min2;
    logic [1:0]  m_idx2;
    logic [2:0]  m_len2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    single_stream_argmin dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_min(m_min), .m_idx(m_idx), .m_len(m_len), .m_nan(m_nan),
        .m_empty(m_empty), .m_ovf(m_ovf), .m_valid(m_valid), .m_ready(m_ready)
    );

    single_stream_argmin #(.IDX_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready2), .m_min(m_min2), .m_idx(m_idx2), .m_len(m_len2), .m_nan(m_nan2),
        .m_empty(m_empty2), .m_ovf(m_ovf2), .m_valid(m_valid2), .m_ready(m_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One accepted sample; on the last one, m_valid must be low before and high right after.
    task automatic send(input logic [31:0] d, input logic last);
        @(negedge clk);
        check("s_ready_in_acc", 32'(s_ready), 32'd1);
        if (last) check("m_valid_pre", 32'(m_valid), 32'd0);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (last) check("m_valid_lat1", 32'(m_valid), 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [31:0] mn, input logic [15:0] idx,
                              input logic [16:0] len, input logic nan, input logic empty,
                              input logic ovf);
        check({tag, "_min"},   m_min, mn);
        check({tag, "_idx"},   32'(m_idx), 32'(idx));
        check({tag, "_len"},   32'(m_len), 32'(len));
        check({tag, "_nan"},   32'(m_nan), 32'(nan));
        check({tag, "_empty"}, 32'(m_empty), 32'(empty));
        check({tag, "_ovf"},   32'(m_ovf), 32'(ovf));
    endtask

    // Take the result; s_ready returns the cycle after m_ready.
    task automatic pop();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("pop_m_valid", 32'(m_valid), 32'd0);
        check("pop_s_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_min",   m_min, 32'h7FC0_0000);
        check("rst_m_len",   32'(m_len), 32'd0);
        check("rst_flags",   {29'd0, m_nan, m_empty, m_ovf}, 32'd0);
        rst_n = 1'b1;

        // s_last without s_valid must be ignored
        @(negedge clk); s_last = 1'b1; @(negedge clk); s_last = 1'b0;
        check("last_no_valid", 32'(m_valid), 32'd0);

        send(32'h4040_0000, 0); send(32'hBFC0_0000, 0);
        send(32'h4000_0000, 0); send(32'hBFC0_0000, 1);
        expect_res("f1", 32'hBFC0_0000, 16'd1, 17'd4, 0, 0, 0);
        // Result held while downstream stalls
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_m_min",   m_min, 32'hBFC0_0000);
            check("hold_m_idx",   32'(m_idx), 32'd1);
        end
        pop();

        send(32'h0000_0000, 0); send(32'h8000_0000, 1);
        expect_res("zero_pos_first", 32'h0000_0000, 16'd0, 17'd2, 0, 0, 0);
        pop();
        send(32'h8000_0000, 0); send(32'h0000_0000, 1);
        expect_res("zero_neg_first", 32'h8000_0000, 16'd0, 17'd2, 0, 0, 0);
        pop();

        send(32'h7FC0_0000, 0); send(32'hFF80_0000, 0); send(32'h7F80_0000, 1);
        expect_res("nan_inf", 32'hFF80_0000, 16'd1, 17'd3, 1, 0, 0);
        pop();
        send(32'h7FC0_0001, 1);
        expect_res("all_nan", 32'h7FC0_0000, 16'd0, 17'd1, 1, 1, 0);
        pop();

        // 6 samples: narrow instance only searches pos 0..3
        send(32'h4000_0000, 0); send(32'h4040_0000, 0); send(32'h3F80_0000, 0);
        send(32'h3FC0_0000, 0); send(32'h3F40_0000, 0); send(32'h3F00_0000, 1);
        check("ovf2_min",  m_min2, 32'h3F80_0000);
        check("ovf2_idx",  32'(m_idx2), 32'd2);
        check("ovf2_len",  32'(m_len2), 32'd6);
        check("ovf2_ovf",  32'(m_ovf2), 32'd1);
        check("ovf2_empty", 32'(m_empty2), 32'd0);
        expect_res("wide6", 32'h3F00_0000, 16'd5, 17'd6, 0, 0, 0);
        pop();

        // Abort a frame with reset mid-stream
        send(32'h3F00_0000, 0); send(32'hC000_0000, 0); send(32'h4000_0000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        send(32'h40A0_0000, 1);
        expect_res("after_abort", 32'h40A0_0000, 16'd0, 17'd1, 0, 0, 0);
        pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
